// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the Booth multiplier front-end: FSM encoding and result flag layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_seq_ctrl_pkg;

    // FSM state encoding, shared with the ALU top
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Flag bit ordering as seen by the ALU top: {err, ovf8, neg, zero}
    localparam int FLG_ZERO = 0;
    localparam int FLG_NEG  = 1;
    localparam int FLG_OVF8 = 2;
    localparam int FLG_ERR  = 3;

    typedef struct packed {
        logic err;
        logic ovf8;
        logic neg;
        logic zero;
    } flags_t;

    // Reports whether a 16-bit product needs more than a signed byte
    function automatic logic ovf8_of(input logic [15:0] p);
        return ~(&p[15:7]) & (|p[15:7]);
    endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Request/response sequencer around the radix-4 Booth multiplier with a hang timeout.
// Latency: accept -> rsp_valid = 1 (issue) + multiplier cycles + 1 (capture).
// Backpressure: req_ready only in IDLE; the result holds in RESP until rsp_ready.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic        mul_start,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_p,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_p,
    output logic        rsp_zero,
    output logic        rsp_neg,
    output logic        rsp_ovf8,
    output logic        rsp_err,
    output logic        busy
);

    // Last WAIT cycle before abort; counter value 0 is the first WAIT cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    flags_t           flags_q;
    flags_t           flags_d;
    logic             timeout_hit;

    assign timeout_hit = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: done takes priority over timeout in the same WAIT cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_valid)               state_nxt = ST_ISSUE;
            ST_ISSUE:                              state_nxt = ST_WAIT;
            ST_WAIT:  if (mul_done || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready)               state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and control outputs decoded from state
    always_comb begin
        req_ready = (state == ST_IDLE);
        mul_start = (state == ST_ISSUE);
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE);
    end

    // Flags derived straight from the multiplier product, registered at capture
    always_comb begin
        flags_d      = '0;
        flags_d.zero = (mul_p == 16'h0000);
        flags_d.neg  = mul_p[15];
        flags_d.ovf8 = ovf8_of(mul_p);
        flags_d.err  = 1'b0;
    end

    // Operand latch, timeout counter and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a   <= '0;
            mul_b   <= '0;
            cnt     <= '0;
            rsp_p   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        mul_a <= req_a;
                        mul_b <= req_b;
                    end
                end
                ST_ISSUE: begin
                    cnt <= '0;
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done) begin
                        rsp_p   <= mul_p;
                        flags_q <= flags_d;
                    end else if (timeout_hit) begin
                        rsp_p       <= '0;
                        flags_q     <= '0;
                        flags_q.err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_zero = flags_q.zero;
    assign rsp_neg  = flags_q.neg;
    assign rsp_ovf8 = flags_q.ovf8;
    assign rsp_err  = flags_q.err;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural Booth multiplier stub.
// Latency: stub asserts done mul_lat edges after it samples start.
// Backpressure: exercised by holding rsp_ready low in RESP.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_a = '0;
    logic [7:0]  req_b = '0;
    logic        mul_start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_done;
    logic [15:0] mul_p;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_p;
    logic        rsp_zero;
    logic        rsp_neg;
    logic        rsp_ovf8;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Stub controls
    int          mul_lat = 12;
    logic        stub_hang = 1'b0;
    logic        stray_done = 1'b0;
    int          stub_cnt;
    logic [15:0] stub_p;
    logic        stub_done;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.TIMEOUT_CYC(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_p(rsp_p), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
        .rsp_ovf8(rsp_ovf8), .rsp_err(rsp_err), .busy(busy)
    );

    // Multiplier stub: shares rst, product computed at start, done after mul_lat edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt <= 0;
            stub_p   <= '0;
        end else if (mul_start) begin
            stub_cnt <= mul_lat;
            stub_p   <= 16'($signed(mul_a) * $signed(mul_b));
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign stub_done = (stub_cnt == 1) && !stub_hang;
    assign mul_done  = stub_done | stray_done;
    assign mul_p     = stray_done ? 16'h1234 : stub_p;

    // Issue one request and wait for rsp_valid; lat = posedges from accept to rsp_valid
    task automatic issue_and_wait(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_idle got=%b want=1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_valid_timeout a=%0d b=%0d waited=%0d", $signed(a), $signed(b), lat);
        end
    endtask

    // Complete the response handshake and confirm return to IDLE
    task automatic drain(input string name);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain rsp_valid=%b req_ready=%b busy=%b want 0/1/0",
                     name, rsp_valid, req_ready, busy);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({mul_start, mul_a, mul_b, rsp_valid, rsp_p, rsp_zero, rsp_neg, rsp_ovf8,
             rsp_err, busy} !== '0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s start=%b a=%h b=%h vld=%b p=%h z=%b n=%b o=%b e=%b busy=%b rdy=%b want all 0, rdy=1",
                     name, mul_start, mul_a, mul_b, rsp_valid, rsp_p, rsp_zero, rsp_neg,
                     rsp_ovf8, rsp_err, busy, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset_release");
    endtask

    task automatic test_products();
        logic [7:0]  va [5] = '{8'd13, 8'hFB, 8'd0,  8'h80, 8'd3};
        logic [7:0]  vb [5] = '{8'd28, 8'd7,  8'hB3, 8'h80, 8'hFC};
        logic [15:0] ep [5] = '{16'h016C, 16'hFFDD, 16'h0000, 16'h4000, 16'hFFF4};
        logic [3:0]  ef [5] = '{4'b0100, 4'b0010, 4'b0001, 4'b0100, 4'b0010}; // {err,ovf8,neg,zero}
        int lat;
        mul_lat = 12;
        for (int i = 0; i < 5; i++) begin
            issue_and_wait(va[i], vb[i], lat);
            checks++;
            if (rsp_p !== ep[i] || {rsp_err, rsp_ovf8, rsp_neg, rsp_zero} !== ef[i]) begin
                failures++;
                $display("FAIL product_%0d p=%h flags=%b want p=%h flags=%b",
                         i, rsp_p, {rsp_err, rsp_ovf8, rsp_neg, rsp_zero}, ep[i], ef[i]);
            end
            checks++;
            if (lat !== 13) begin
                failures++;
                $display("FAIL latency_%0d got=%0d want=13", i, lat);
            end
            drain($sformatf("product_%0d", i));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] p0;
        int bad = 0;
        issue_and_wait(8'hF6, 8'd9, lat);     // -10 * 9 = -90 = 0xFFA6
        p0 = rsp_p;
        checks++;
        if (p0 !== 16'hFFA6) begin
            failures++;
            $display("FAIL bp_product got=%h want=ffa6", p0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_p !== 16'hFFA6 || req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d want=0 (vld=%b p=%h rdy=%b)",
                     bad, rsp_valid, rsp_p, req_ready);
        end
        drain("backpressure");
    endtask

    task automatic test_timeout();
        int lat;
        stub_hang = 1'b1;
        issue_and_wait(8'd5, 8'd6, lat);
        stub_hang = 1'b0;
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL timeout_latency got=%0d want=33", lat);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_p !== 16'h0000 || {rsp_ovf8, rsp_neg, rsp_zero} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_result err=%b p=%h flags=%b want err=1 p=0 flags=000",
                     rsp_err, rsp_p, {rsp_ovf8, rsp_neg, rsp_zero});
        end
        drain("timeout");
        issue_and_wait(8'd5, 8'd6, lat);
        checks++;
        if (rsp_err !== 1'b0 || rsp_p !== 16'd30 || lat !== 13) begin
            failures++;
            $display("FAIL after_timeout err=%b p=%h lat=%0d want err=0 p=001e lat=13",
                     rsp_err, rsp_p, lat);
        end
        drain("after_timeout");
    endtask

    task automatic test_done_at_timeout();
        int lat;
        mul_lat = 32;                         // done lands on the last WAIT cycle
        issue_and_wait(8'hFF, 8'hFF, lat);    // -1 * -1 = 1
        mul_lat = 12;
        checks++;
        if (lat !== 33 || rsp_err !== 1'b0 || rsp_p !== 16'h0001) begin
            failures++;
            $display("FAIL done_wins_timeout lat=%0d err=%b p=%h want lat=33 err=0 p=0001",
                     lat, rsp_err, rsp_p);
        end
        drain("done_at_timeout");
    endtask

    task automatic test_reset_in_wait();
        int seen = 0;
        @(negedge clk);
        req_a = 8'd7;
        req_b = 8'd7;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mul_a !== 8'd7) begin
            failures++;
            $display("FAIL wait_before_reset busy=%b mul_a=%h want 1/07", busy, mul_a);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_in_wait");
        rst = 1'b0;
        // stray done in IDLE must be ignored
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid || busy || rsp_p !== 16'h0000) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL stray_done_idle bad_cycles=%0d want=0", seen);
        end
        check_idle_outputs("idle_after_stray");
    endtask

    initial begin
        test_reset();
        test_products();
        test_backpressure();
        test_timeout();
        test_done_at_timeout();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a task loop misbehaves
    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
